// File: rtl/overflow_interval_tracker_pkg.sv
// Shared types and helpers for the overflow-interval store: store sizes,
// tracker states, the {first, last} interval record and range arithmetic.
package overflow_pkg;

   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } store_size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      OPEN  = 2'd2
   } tracker_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] first;
      logic [ADDR_W-1:0] last;
   } interval_t;

   function automatic logic [3:0] size_bytes(input store_size_e sz);
      case (sz)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         SZ_D:    return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

   // Last byte touched; a carry out of the address space clamps to the top byte.
   function automatic logic [ADDR_W-1:0] access_end(input logic [ADDR_W-1:0] addr,
                                                   input store_size_e sz);
      logic [ADDR_W:0] end_x;
      end_x = {1'b0, addr} + {29'd0, size_bytes(sz)} - 33'd1;
      return end_x[ADDR_W] ? {ADDR_W{1'b1}} : end_x[ADDR_W-1:0];
   endfunction

   function automatic logic merges(input logic [ADDR_W-1:0] addr,
                                   input interval_t iv,
                                   input logic [ADDR_W:0] gap);
      return (addr >= iv.first) &&
             ({1'b0, addr} <= ({1'b0, iv.last} + 33'd1 + gap));
   endfunction

endpackage

// File: rtl/overflow_interval_tracker_if.sv
// Store-commit tap in, interval-buffer write port out.
interface overflow_interval_tracker_if;
   import overflow_pkg::*;

   logic              store_valid;
   logic [ADDR_W-1:0] store_addr;
   logic [1:0]        store_size;
   logic              en_write;
   logic [ADDR_W-1:0] addr_first;
   logic [ADDR_W-1:0] addr_last;

   modport master (
      output store_valid, store_addr, store_size,
      input  en_write, addr_first, addr_last
   );

   modport slave (
      input  store_valid, store_addr, store_size,
      output en_write, addr_first, addr_last
   );

endinterface

// File: rtl/overflow_interval_tracker_chk.sv
// Flags an arm with inverted bounds, which leaves tracker behaviour undefined.
module overflow_interval_tracker_chk (
   input logic        clk_i,
   input logic        rst_ni,
   input logic        arm_i,
   input logic [31:0] bound_lo_i,
   input logic [31:0] bound_hi_i
);

   // Sample the bounds on every effective arm
   always @(posedge clk_i) begin
      if (rst_ni && arm_i) begin
         assert (bound_lo_i <= bound_hi_i)
            else $error("overflow_interval_tracker: bound_lo %h above bound_hi %h", bound_lo_i, bound_hi_i);
      end
   end

endmodule

// File: rtl/overflow_interval_tracker.sv
// Watches committed stores against an armed buffer's bounds and emits each
// coalesced out-of-bounds interval as one write into the interval buffer.
module overflow_interval_tracker
   import overflow_pkg::*;
#(
   parameter int unsigned GAP     = 0,
   parameter int unsigned COUNT_W = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         arm_i,
   input  logic                         disarm_i,
   input  logic [ADDR_W-1:0]            bound_lo_i,
   input  logic [ADDR_W-1:0]            bound_hi_i,
   overflow_interval_tracker_if.slave   bus,
   output logic                         busy_o,
   output logic                         overflow_detected_o,
   output logic [COUNT_W-1:0]           interval_count_o
);

   localparam logic [ADDR_W:0] GAP_X = (ADDR_W+1)'(GAP);

   tracker_state_e     state_r;
   interval_t          iv_r;
   interval_t          out_iv_r;
   logic [ADDR_W-1:0]  lo_r;
   logic [ADDR_W-1:0]  hi_r;
   logic               en_r;
   logic               flush_pend_r;
   logic               clear_pend_r;
   logic               sticky_r;
   logic [COUNT_W-1:0] cnt_r;

   store_size_e        size_s;
   logic [ADDR_W-1:0]  end_s;
   logic [ADDR_W-1:0]  merged_last_s;
   logic               arm_only_s;
   logic               hit_s;
   logic               merge_s;
   logic               emit_s;
   interval_t          emit_iv_s;
   interval_t          new_iv_s;
   logic [COUNT_W-1:0] cnt_base_s;
   logic [COUNT_W-1:0] cnt_inc_s;
   logic               sticky_base_s;

   // Classify the current store and decide whether an interval leaves this cycle
   always_comb begin
      size_s        = store_size_e'(bus.store_size);
      end_s         = access_end(bus.store_addr, size_s);
      new_iv_s      = '{first: bus.store_addr, last: end_s};
      merged_last_s = (end_s > iv_r.last) ? end_s : iv_r.last;
      arm_only_s    = arm_i && !disarm_i;
      hit_s         = 1'b0;
      merge_s       = 1'b0;
      emit_s        = 1'b0;
      emit_iv_s     = iv_r;
      if (((state_r == ARMED) || ((state_r == OPEN) && !flush_pend_r)) &&
          bus.store_valid && !arm_only_s &&
          ((bus.store_addr < lo_r) || (end_s > hi_r))) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
      if ((state_r == OPEN) && hit_s) begin
         merge_s = merges(bus.store_addr, iv_r, GAP_X);
      end else begin
         merge_s = 1'b0;
      end
      case (state_r)
         ARMED: begin
            if (disarm_i && hit_s) begin
               emit_s    = 1'b1;
               emit_iv_s = new_iv_s;
            end else begin
               emit_s    = 1'b0;
            end
         end
         OPEN: begin
            if (flush_pend_r || arm_i || (hit_s && !merge_s)) begin
               emit_s    = 1'b1;
            end else if (disarm_i) begin
               emit_s    = 1'b1;
               emit_iv_s = merge_s ? '{first: iv_r.first, last: merged_last_s} : iv_r;
            end else begin
               emit_s    = 1'b0;
            end
            // Disarm with a merging store flushes the already-extended interval
            if (!flush_pend_r && disarm_i && merge_s) begin
               emit_iv_s = '{first: iv_r.first, last: merged_last_s};
            end else begin
               emit_iv_s = emit_iv_s;
            end
         end
         default: begin
            emit_s = 1'b0;
         end
      endcase
      cnt_base_s    = clear_pend_r ? {COUNT_W{1'b0}} : cnt_r;
      sticky_base_s = clear_pend_r ? 1'b0 : sticky_r;
      cnt_inc_s     = (cnt_base_s == {COUNT_W{1'b1}}) ? cnt_base_s : (cnt_base_s + COUNT_W'(1));
   end

   // Tracker FSM with registered emission, counter and sticky flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= IDLE;
         iv_r         <= '{first: 32'd0, last: 32'd0};
         out_iv_r     <= '{first: 32'd0, last: 32'd0};
         lo_r         <= 32'd0;
         hi_r         <= 32'd0;
         en_r         <= 1'b0;
         flush_pend_r <= 1'b0;
         clear_pend_r <= 1'b0;
         sticky_r     <= 1'b0;
         cnt_r        <= {COUNT_W{1'b0}};
      end else begin
         en_r         <= emit_s;
         out_iv_r     <= emit_s ? emit_iv_s : out_iv_r;
         cnt_r        <= emit_s ? cnt_inc_s : cnt_base_s;
         sticky_r     <= sticky_base_s | hit_s;
         clear_pend_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (arm_only_s) begin
                  lo_r     <= bound_lo_i;
                  hi_r     <= bound_hi_i;
                  cnt_r    <= {COUNT_W{1'b0}};
                  sticky_r <= 1'b0;
                  state_r  <= ARMED;
               end else begin
                  state_r  <= IDLE;
               end
            end
            ARMED: begin
               if (disarm_i) begin
                  state_r  <= IDLE;
               end else if (arm_i) begin
                  lo_r     <= bound_lo_i;
                  hi_r     <= bound_hi_i;
                  cnt_r    <= {COUNT_W{1'b0}};
                  sticky_r <= 1'b0;
                  state_r  <= ARMED;
               end else if (hit_s) begin
                  iv_r     <= new_iv_s;
                  state_r  <= OPEN;
               end else begin
                  state_r  <= ARMED;
               end
            end
            OPEN: begin
               if (flush_pend_r) begin
                  flush_pend_r <= 1'b0;
                  state_r      <= IDLE;
               end else if (disarm_i) begin
                  // A fresh interval opened alongside disarm drains on the next cycle
                  if (hit_s && !merge_s) begin
                     iv_r         <= new_iv_s;
                     flush_pend_r <= 1'b1;
                     state_r      <= OPEN;
                  end else begin
                     state_r      <= IDLE;
                  end
               end else if (arm_i) begin
                  lo_r         <= bound_lo_i;
                  hi_r         <= bound_hi_i;
                  clear_pend_r <= 1'b1;
                  state_r      <= ARMED;
               end else if (merge_s) begin
                  iv_r.last    <= merged_last_s;
               end else if (hit_s) begin
                  iv_r         <= new_iv_s;
               end else begin
                  state_r      <= OPEN;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.en_write         = en_r;
   assign bus.addr_first       = out_iv_r.first;
   assign bus.addr_last        = out_iv_r.last;
   assign busy_o               = (state_r == OPEN);
   assign overflow_detected_o  = sticky_r;
   assign interval_count_o     = cnt_r;

   overflow_interval_tracker_chk u_chk (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .arm_i      (arm_only_s),
      .bound_lo_i (bound_lo_i),
      .bound_hi_i (bound_hi_i)
   );

endmodule
